// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Multiplies take 5 cycles and divides 10; the result is written at the end.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic [31:0] E_MDData,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int unsigned W       = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [W-1:0]       hi, hi_d, lo, lo_d;

  logic               is_mul, is_sdiv, launch_op;
  logic [2*W-1:0]     mul_a, mul_b, prod;
  logic               a_neg, b_neg;
  logic [W-1:0]       a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Datapath on captured operands; only sampled at the completing edge.
  always_comb begin
    is_mul  = (op_q == OP_MULT) || (op_q == OP_MULTU);
    is_sdiv = (op_q == OP_DIV);
    mul_a   = (op_q == OP_MULT) ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    mul_b   = (op_q == OP_MULT) ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    prod    = mul_a * mul_b;

    // Signed divide through magnitudes so INT_MIN / -1 wraps cleanly.
    a_neg = is_sdiv & a_q[W-1];
    b_neg = is_sdiv & b_q[W-1];
    a_mag = a_neg ? (~a_q + W'(1)) : a_q;
    b_mag = b_neg ? (~b_q + W'(1)) : b_q;
    q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
    r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
    quot  = (a_neg ^ b_neg) ? (~q_mag + W'(1)) : q_mag;
    rem   = a_neg ? (~r_mag + W'(1)) : r_mag;
  end

  assign launch_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU) ||
                     (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);

  // Next-state and register updates.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi;
    lo_d    = lo;
    case (state)
      S_IDLE: begin
        if (E_Start && launch_op) begin
          state_d = S_BUSY;
          cnt_d   = ((E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU)) ?
                    CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
          op_d    = E_MDOp;
          a_d     = E_RS;
          b_d     = E_RT;
        end
        if (E_MDOp == OP_MTHI) hi_d = E_RS;
        if (E_MDOp == OP_MTLO) lo_d = E_RS;
      end
      S_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (is_mul) begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi    <= hi_d;
      lo    <= lo_d;
    end
  end

  assign E_Busy   = (state == S_BUSY);
  assign E_HI     = hi;
  assign E_LO     = lo;
  assign E_MDData = (E_MDOp == OP_MFHI) ? hi :
                    (E_MDOp == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of mult/div results plus
// hand sequences for divide-by-zero, busy-time interference and reset.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic        E_Start;
  logic [31:0] E_RS, E_RT;
  logic [31:0] E_MDData, E_HI, E_LO;
  logic        E_Busy;

  int checks = 0;
  int errors = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_Start(E_Start),
    .E_RS(E_RS), .E_RT(E_RT), .E_MDData(E_MDData), .E_Busy(E_Busy),
    .E_HI(E_HI), .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch at the next posedge; returns at the negedge of busy cycle 1.
  task automatic launch(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    E_MDOp = op; E_Start = 1'b1; E_RS = rs; E_RT = rt;
    @(negedge clk);
    E_MDOp = 4'd0; E_Start = 1'b0;
  endtask

  // Count busy cycles while checking HI/LO stay frozen.
  task automatic count_busy(input logic [31:0] h0, input logic [31:0] l0, output int n, output bit moved);
    n = 0; moved = 1'b0;
    while (E_Busy === 1'b1 && n < 40) begin
      if (E_HI !== h0 || E_LO !== l0) moved = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val);
    @(negedge clk);
    E_MDOp = op; E_RS = val;
    @(negedge clk);
    E_MDOp = 4'd0;
  endtask

  initial begin
    int n;
    bit moved;
    logic [31:0] h0, l0;

    vecs[0]  = '{4'd1, 32'h00000003, 32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
    vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{4'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[7]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[8]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
    vecs[9]  = '{4'd4, 32'hFFFFFFFF, 32'd10,       10, 32'h00000005, 32'h19999999};
    vecs[10] = '{4'd3, 32'h00000055, 32'h00000000, 10, 32'h00000005, 32'h19999999};

    reset = 1'b1; E_MDOp = 4'd0; E_Start = 1'b0; E_RS = '0; E_RT = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(E_Busy), 32'd0);
    chk("reset_hi", E_HI, 32'd0);
    chk("reset_lo", E_LO, 32'd0);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      h0 = E_HI; l0 = E_LO;
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
      count_busy(h0, l0, n, moved);
      chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].busy));
      chk($sformatf("v%0d_hold", i), 32'(moved), 32'd0);
      chk($sformatf("v%0d_hi", i), E_HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), E_LO, vecs[i].lo);
      E_MDOp = 4'd5; #1;
      chk($sformatf("v%0d_mfhi", i), E_MDData, vecs[i].hi);
      E_MDOp = 4'd6; #1;
      chk($sformatf("v%0d_mflo", i), E_MDData, vecs[i].lo);
      E_MDOp = 4'd0;
    end

    // Idle moves, unused opcode reads zero, Start with non-md op does nothing.
    move_to(4'd7, 32'hCAFE0001);
    move_to(4'd8, 32'hCAFE0002);
    chk("mthi_idle", E_HI, 32'hCAFE0001);
    chk("mtlo_idle", E_LO, 32'hCAFE0002);
    E_MDOp = 4'd9; #1;
    chk("op9_data", E_MDData, 32'd0);
    @(negedge clk);
    E_MDOp = 4'd5; E_Start = 1'b1;
    @(negedge clk);
    chk("start_mfhi_no_busy", 32'(E_Busy), 32'd0);
    E_MDOp = 4'd0; E_Start = 1'b0;

    // divu by zero after mtlo keeps HI/LO.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    move_to(4'd8, 32'h00001234);
    launch(4'd4, 32'd5, 32'd0);
    count_busy(32'd0, 32'h00001234, n, moved);
    chk("dz_busy_cycles", 32'(n), 32'd10);
    chk("dz_lo", E_LO, 32'h00001234);
    chk("dz_hi", E_HI, 32'd0);

    // mthi and a second launch during div busy are ignored.
    launch(4'd3, 32'hFFFFFFF9, 32'd2);
    n = 1;
    E_MDOp = 4'd7; E_RS = 32'h0000AAAA;
    @(negedge clk); n++;
    chk("busy_mthi_ignored", E_HI, 32'd0);
    E_MDOp = 4'd1; E_Start = 1'b1; E_RS = 32'd3; E_RT = 32'd5;
    @(negedge clk); n++;
    E_MDOp = 4'd5; E_Start = 1'b0;
    #1 chk("busy_mfhi_current", E_MDData, 32'd0);
    while (E_Busy === 1'b1 && n < 40) begin
      @(negedge clk);
      if (E_Busy === 1'b1) n++;
    end
    E_MDOp = 4'd0;
    chk("interf_busy_cycles", 32'(n), 32'd10);
    chk("interf_hi", E_HI, 32'hFFFFFFFF);
    chk("interf_lo", E_LO, 32'hFFFFFFFD);
    repeat (3) @(negedge clk);
    chk("interf_no_relaunch", 32'(E_Busy), 32'd0);

    // Reset in busy cycle 3 of a mult cancels it.
    launch(4'd1, 32'd3, 32'hFFFFFFFE);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_was_busy", 32'(E_Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(E_Busy), 32'd0);
    chk("rst_mid_hi", E_HI, 32'd0);
    chk("rst_mid_lo", E_LO, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_late_hi", E_HI, 32'd0);
    chk("rst_late_lo", E_LO, 32'd0);
    chk("rst_late_busy", 32'(E_Busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
